button_event_ctrl: RTL
======================

BUTTON_EVENT_CTRL -- requirements
Module: button_event_ctrl

Interface
REQ-001 Parameter: N_BTN, 4, number of debounced buttons served (fixed 4 in this revision).
REQ-002 Parameter: REPEAT_DELAY, 12000000, held cycles before first auto-repeat.
REQ-003 Parameter: REPEAT_PERIOD, 3000000, cycles between later auto-repeats.
REQ-004 Parameter: FIFO_DEPTH, 4, event queue entries (power of 2).
REQ-005 clk  in  1  single clock; all logic posedge clk.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 btn_level  in  4  debounced level per button.
REQ-008 btn_press  in  4  one-cycle press pulse per button from debouncer.
REQ-009 btn_release  in  4  one-cycle release pulse per button from debouncer.
REQ-010 repeat_en  in  4  per-button auto-repeat enable.
REQ-011 evt_valid  out  1  head event available.
REQ-012 evt_ready  in  1  consumer accepts head event when high with evt_valid.
REQ-013 evt_btn  out  2  button index of head event.
REQ-014 evt_type  out  2  00 press, 01 release, 10 repeat; 11 never emitted.
REQ-015 overflow  out  1  sticky: an event was lost.
REQ-016 clr_overflow  in  1  clears overflow.

Function
REQ-017 Per-button FSM SHALL have states IDLE, HELD, REPEAT, with a 24-bit hold counter per button.
REQ-018 IDLE->HELD on btn_press: set pending_press, clear counter.
REQ-019 HELD: counter +1 per cycle while btn_level=1 and repeat_en=1; at counter==REPEAT_DELAY-1 set pending_repeat, clear counter, go REPEAT.
REQ-020 REPEAT: at counter==REPEAT_PERIOD-1 set pending_repeat, clear counter, stay.
REQ-021 HELD or REPEAT: btn_release SHALL set pending_release and go IDLE; repeat_en=0 SHALL hold the counter at 0 and the state unchanged.
REQ-022 Simultaneous btn_press and btn_release for one button: release processed first, then press; net state HELD; both pending bits set.
REQ-023 Pending bits per button: press, release, repeat (12 total); a pending bit stays set until pushed into the FIFO.
REQ-024 New event whose pending bit is already set and not being pushed that cycle SHALL be dropped and set overflow.
REQ-025 Scheduler pushes at most one pending event per cycle when FIFO not full; round-robin over buttons starting after the last-served index; within a button priority release > press > repeat.
REQ-026 Pending bit pushed and re-set by a new event in the same cycle SHALL end set (no loss, no overflow).
REQ-027 FIFO: FIFO_DEPTH entries of {btn,type}; push and pop in the same cycle allowed, including when full (pop frees the slot for that cycle's push).
REQ-028 evt_valid = FIFO non-empty; evt_btn/evt_type show the head and SHALL be stable while evt_valid=1 and evt_ready=0.
REQ-029 Latency: event pulse at cycle t, empty FIFO, no competing pending -> evt_valid=1 at t+2.
REQ-030 Event ordering per button SHALL be preserved; cross-button ordering follows REQ-025.
REQ-031 overflow set and clr_overflow same cycle: overflow stays 1.

Reset
REQ-032 rst=1 at a clock edge: all FSMs IDLE, counters 0, pending bits 0, FIFO empty, round-robin pointer 0, evt_valid=0, evt_btn=0, evt_type=0, overflow=0.
REQ-033 Reset mid-hold or with FIFO non-empty SHALL discard all state; no event is emitted for buttons still held after reset until a fresh btn_press.

Verification
REQ-034 Press btn 2, evt_ready=1 -> evt_valid at t+2 with evt_btn=2, evt_type=00, one cycle only.
REQ-035 REPEAT_DELAY=10, REPEAT_PERIOD=4, hold btn 0 with repeat_en=1 for 30 cycles, then release -> press, repeat at +10, repeats every 4 after, then release; 5 repeats total.
REQ-036 Press btns 0-3 in the same cycle, evt_ready=0 -> FIFO fills with btn order 0,1,2,3; evt_valid stays 1 with head btn 0 unchanged.
REQ-037 FIFO full, evt_ready=0, press then release btn 1 twice -> second press dropped, overflow=1; clr_overflow -> overflow=0.
REQ-038 Full FIFO with evt_ready=1 and a pending event -> one pop and one push in the same cycle; occupancy unchanged, no overflow.
REQ-039 Assert rst while btn 3 in REPEAT with 3 queued events -> next cycle evt_valid=0, overflow=0, no repeat events while btn_level stays 1.

Source files
------------

// File: rtl/button_event_ctrl.sv
// Button event controller: per-button press/hold/repeat tracking, pending-event
// arbitration and a small event FIFO toward a single consumer.
module button_event_ctrl #(
  parameter int N_BTN         = 4,
  parameter int REPEAT_DELAY  = 12000000,
  parameter int REPEAT_PERIOD = 3000000,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_level,
  input  logic [N_BTN-1:0] btn_press,
  input  logic [N_BTN-1:0] btn_release,
  input  logic [N_BTN-1:0] repeat_en,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_btn,
  output logic [1:0]       evt_type,
  output logic             overflow,
  input  logic             clr_overflow
);

  typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

  localparam logic [1:0]  EVT_PRESS   = 2'b00;
  localparam logic [1:0]  EVT_RELEASE = 2'b01;
  localparam logic [1:0]  EVT_REPEAT  = 2'b10;
  localparam logic [23:0] DELAY_M1    = 24'(REPEAT_DELAY - 1);
  localparam logic [23:0] PERIOD_M1   = 24'(REPEAT_PERIOD - 1);
  localparam int          AW          = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT    = (AW + 1)'(FIFO_DEPTH);

  state_t      state_q [N_BTN];
  state_t      state_d [N_BTN];
  logic [23:0] cnt_q   [N_BTN];
  logic [23:0] cnt_d   [N_BTN];

  logic [N_BTN-1:0] new_press, new_release, new_repeat;
  logic [N_BTN-1:0] pend_press, pend_release, pend_repeat;
  logic [N_BTN-1:0] push_press, push_release, push_repeat;
  logic [N_BTN-1:0] drop_mask;

  logic [1:0] rr_ptr;
  logic [1:0] scan_idx;
  logic       sel_valid;
  logic [1:0] sel_btn;
  logic [1:0] sel_type;
  logic       do_push;
  logic       do_pop;

  logic [3:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_full;
  logic [3:0]    head;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < N_BTN; b++) begin
        state_q[b] <= IDLE;
        cnt_q[b]   <= '0;
      end
    end else begin
      for (int b = 0; b < N_BTN; b++) begin
        state_q[b] <= state_d[b];
        cnt_q[b]   <= cnt_d[b];
      end
    end
  end

  // A same-cycle press+release is treated as release-then-press: both events, ends HELD.
  always_comb begin
    new_press   = '0;
    new_release = '0;
    new_repeat  = '0;
    for (int b = 0; b < N_BTN; b++) begin
      state_d[b] = state_q[b];
      cnt_d[b]   = cnt_q[b];
      if (btn_press[b] && btn_release[b]) begin
        new_release[b] = 1'b1;
        new_press[b]   = 1'b1;
        state_d[b]     = HELD;
        cnt_d[b]       = '0;
      end else begin
        case (state_q[b])
          IDLE: begin
            if (btn_press[b]) begin
              new_press[b] = 1'b1;
              state_d[b]   = HELD;
              cnt_d[b]     = '0;
            end
          end
          HELD, REPEAT: begin
            if (btn_release[b]) begin
              new_release[b] = 1'b1;
              state_d[b]     = IDLE;
              cnt_d[b]       = '0;
            end else if (!repeat_en[b]) begin
              cnt_d[b] = '0;
            end else if (btn_level[b]) begin
              if (cnt_q[b] == ((state_q[b] == HELD) ? DELAY_M1 : PERIOD_M1)) begin
                new_repeat[b] = 1'b1;
                state_d[b]    = REPEAT;
                cnt_d[b]      = '0;
              end else begin
                cnt_d[b] = cnt_q[b] + 24'd1;
              end
            end
          end
          default: begin
            state_d[b] = IDLE;
            cnt_d[b]   = '0;
          end
        endcase
      end
    end
  end

  // Round-robin scan starts at rr_ptr, which always points one past the last served button.
  always_comb begin
    sel_valid = 1'b0;
    sel_btn   = '0;
    sel_type  = EVT_PRESS;
    scan_idx  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      scan_idx = rr_ptr + 2'(i);
      if (!sel_valid && (pend_release[scan_idx] || pend_press[scan_idx] || pend_repeat[scan_idx])) begin
        sel_valid = 1'b1;
        sel_btn   = scan_idx;
        if (pend_release[scan_idx])    sel_type = EVT_RELEASE;
        else if (pend_press[scan_idx]) sel_type = EVT_PRESS;
        else                           sel_type = EVT_REPEAT;
      end
    end
  end

  assign do_pop  = evt_valid && evt_ready;
  assign do_push = sel_valid && (!fifo_full || do_pop);

  always_comb begin
    push_press   = '0;
    push_release = '0;
    push_repeat  = '0;
    if (do_push) begin
      case (sel_type)
        EVT_RELEASE: push_release[sel_btn] = 1'b1;
        EVT_PRESS:   push_press[sel_btn]   = 1'b1;
        default:     push_repeat[sel_btn]  = 1'b1;
      endcase
    end
  end

  assign drop_mask = (new_press   & pend_press   & ~push_press)
                   | (new_release & pend_release & ~push_release)
                   | (new_repeat  & pend_repeat  & ~push_repeat);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_press   <= '0;
      pend_release <= '0;
      pend_repeat  <= '0;
      rr_ptr       <= '0;
      overflow     <= 1'b0;
    end else begin
      pend_press   <= (pend_press   & ~push_press)   | new_press;
      pend_release <= (pend_release & ~push_release) | new_release;
      pend_repeat  <= (pend_repeat  & ~push_repeat)  | new_repeat;
      if (do_push) rr_ptr <= sel_btn + 2'd1;
      if (|drop_mask)        overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  // Storage is left unreset; outputs are masked with evt_valid instead.
  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= {sel_btn, sel_type};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW + 1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW + 1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign fifo_full = (fifo_cnt == FULL_CNT);
  assign evt_valid = (fifo_cnt != '0);
  assign head      = fifo_mem[rd_ptr];
  assign evt_btn   = evt_valid ? head[3:2] : 2'b00;
  assign evt_type  = evt_valid ? head[1:0] : 2'b00;

endmodule
